pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the five-stage pipeline.
- Drives the load and flush enables of the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers from four inputs: instruction-fetch wait, data-memory wait, load-use hazard and EX-stage redirect.
- Holds an EX redirect that resolves while a fetch is outstanding. It squashes the late wrong-path fetch and replays the saved target.
- Keeps saturating performance counters for stall and flush events.

---
 rtl/rv32i_types.sv | 11 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 25 ++
 rtl/pipeline_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the pipeline control path: hazard FSM states and register-file constants.
package rv32i_types;

    typedef enum logic {
        HZ_RUN    = 1'b0,
        HZ_SQUASH = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencer: register enables/flushes from fetch wait, data wait,
// load-use and redirect, with a squash state that replays a redirect caught behind a slow fetch.
module pipeline_hazard_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_resp,
    input  logic              dmem_req,
    input  logic              dmem_resp,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [4:0]        ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_redirect,
    input  logic [ADDR_W-1:0] ex_target,
    output logic              load_pc,
    output logic              pc_sel_redirect,
    output logic [ADDR_W-1:0] pc_target,
    output logic              load_if_id,
    output logic              load_id_ex,
    output logic              load_ex_mem,
    output logic              load_mem_wb,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  loaduse_cnt
);

    hz_state_t         state_q, state_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic              dstall, istall, lu;
    logic              stall_inc, flush_inc, lu_inc;

    assign dstall = dmem_req & ~dmem_resp;
    assign istall = ~imem_resp;
    assign lu     = ex_mem_read & (ex_rd != REG_ZERO) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    always_comb begin
        state_d         = state_q;
        tgt_d           = tgt_q;
        load_pc         = 1'b0;
        pc_sel_redirect = 1'b0;
        pc_target       = (state_q == HZ_SQUASH) ? tgt_q : ex_target;
        load_if_id      = 1'b0;
        load_id_ex      = 1'b0;
        load_ex_mem     = 1'b0;
        load_mem_wb     = 1'b0;
        flush_if_id     = 1'b0;
        flush_id_ex     = 1'b0;
        flush_inc       = 1'b0;
        lu_inc          = 1'b0;
        if (!rst) begin
            // Outputs are forced quiet combinationally so reset takes effect without a clock.
            pc_target = '0;
        end else if (dstall) begin
            // Whole pipe frozen; stall_cnt still sees load_pc=0 below.
        end else if (state_q == HZ_SQUASH) begin
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            load_id_ex  = 1'b1;
            flush_id_ex = 1'b1;
            if (imem_resp) begin
                load_pc         = 1'b1;
                pc_sel_redirect = 1'b1;
                load_if_id      = 1'b1;
                flush_if_id     = 1'b1;
                state_d         = HZ_RUN;
            end
        end else if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_inc   = 1'b1;
            if (imem_resp) begin
                load_pc         = 1'b1;
                pc_sel_redirect = 1'b1;
            end else begin
                tgt_d   = ex_target;
                state_d = HZ_SQUASH;
            end
        end else if (lu || istall) begin
            load_id_ex  = 1'b1;
            flush_id_ex = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            lu_inc      = lu;
        end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
        end
        stall_inc = rst & ~load_pc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= HZ_RUN;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .rst(rst), .inc(stall_inc), .count(stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .rst(rst), .inc(flush_inc), .count(flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_loaduse_cnt (
        .clk(clk), .rst(rst), .inc(lu_inc), .count(loaduse_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with 2-bit counters covers saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_resp, dmem_req, dmem_resp;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
    logic [31:0] ex_target;

    logic        load_pc, pc_sel_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex;
    logic [31:0] pc_target, stall_cnt, flush_cnt, loaduse_cnt;

    logic        s_load_pc, s_sel, s_lif, s_lidex, s_lem, s_lmw, s_fif, s_fidex;
    logic [31:0] s_pc_target;
    logic [1:0]  s_stall_cnt, s_flush_cnt, s_loaduse_cnt;

    logic [7:0]  en;
    int          checks   = 0;
    int          failures = 0;

    // {load_pc, pc_sel_redirect, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}
    localparam logic [7:0] EN_NONE   = 8'h00;
    localparam logic [7:0] EN_NORMAL = 8'hBC;
    localparam logic [7:0] EN_BUBBLE = 8'h1D;
    localparam logic [7:0] EN_REDIR  = 8'hFF;
    localparam logic [7:0] EN_RWAIT  = 8'h3F;

    assign en = {load_pc, pc_sel_redirect, load_if_id, load_id_ex,
                 load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .load_pc(load_pc), .pc_sel_redirect(pc_sel_redirect), .pc_target(pc_target),
        .load_if_id(load_if_id), .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
        .load_mem_wb(load_mem_wb), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .loaduse_cnt(loaduse_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .ADDR_W(32)) dut_sat (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .load_pc(s_load_pc), .pc_sel_redirect(s_sel), .pc_target(s_pc_target),
        .load_if_id(s_lif), .load_id_ex(s_lidex), .load_ex_mem(s_lem),
        .load_mem_wb(s_lmw), .flush_if_id(s_fif), .flush_id_ex(s_fidex),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .loaduse_cnt(s_loaduse_cnt)
    );

    task automatic idle();
        imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; idle();
        #3;
        checks++;
        if (en !== EN_NONE || pc_target !== 32'h0) begin
            failures++; $display("FAIL reset_outputs en=%h pc_target=%h want en=%h pc_target=0", en, pc_target, EN_NONE);
        end
        checks++;
        if ({stall_cnt, flush_cnt, loaduse_cnt} !== 96'h0) begin
            failures++; $display("FAIL reset_counters got %h/%h/%h want 0/0/0", stall_cnt, flush_cnt, loaduse_cnt);
        end
        step(); rst = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== EN_NORMAL) begin
            failures++; $display("FAIL run_normal en=%h want %h", en, EN_NORMAL);
        end
        step();
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== EN_BUBBLE) begin
            failures++; $display("FAIL lu_rs1_bubble en=%h want %h", en, EN_BUBBLE);
        end
        step(); idle();
        @(negedge clk);
        checks++;
        if (en !== EN_NORMAL || loaduse_cnt !== 32'd1 || stall_cnt !== 32'd1) begin
            failures++; $display("FAIL lu_one_cycle en=%h lu=%0d stall=%0d want en=%h lu=1 stall=1", en, loaduse_cnt, stall_cnt, EN_NORMAL);
        end
        step();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== EN_NORMAL) begin
            failures++; $display("FAIL lu_x0_no_bubble en=%h want %h", en, EN_NORMAL);
        end
        step();
        ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs1 = 1'b0; id_use_rs2 = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== EN_BUBBLE) begin
            failures++; $display("FAIL lu_rs2_bubble en=%h want %h", en, EN_BUBBLE);
        end
        step();
        id_use_rs2 = 1'b0;
        @(negedge clk);
        checks++;
        if (en !== EN_NORMAL || loaduse_cnt !== 32'd2 || stall_cnt !== 32'd2) begin
            failures++; $display("FAIL lu_unused_src en=%h lu=%0d stall=%0d want en=%h lu=2 stall=2", en, loaduse_cnt, stall_cnt, EN_NORMAL);
        end
        step(); idle();
    endtask

    task automatic test_redirect_ready();
        ex_redirect = 1'b1; ex_target = 32'h0000_0480;
        @(negedge clk);
        checks++;
        if (en !== EN_REDIR || pc_target !== 32'h480) begin
            failures++; $display("FAIL redir_ready en=%h pc_target=%h want en=%h pc_target=480", en, pc_target, EN_REDIR);
        end
        step(); idle();
        checks++;
        if (flush_cnt !== 32'd1 || stall_cnt !== 32'd2) begin
            failures++; $display("FAIL redir_ready_cnt flush=%0d stall=%0d want 1/2", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_redirect_wait();
        ex_redirect = 1'b1; ex_target = 32'h600; imem_resp = 1'b0;
        @(negedge clk);
        checks++;
        if (en !== EN_RWAIT) begin
            failures++; $display("FAIL redir_wait_accept en=%h want %h", en, EN_RWAIT);
        end
        step();
        ex_target = 32'h999;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (en !== EN_BUBBLE || pc_target !== 32'h600) begin
                failures++; $display("FAIL squash_hold%0d en=%h pc_target=%h want en=%h pc_target=600", i, en, pc_target, EN_BUBBLE);
            end
            step();
        end
        checks++;
        if (stall_cnt !== 32'd5 || flush_cnt !== 32'd2) begin
            failures++; $display("FAIL squash_cnt stall=%0d flush=%0d want 5/2", stall_cnt, flush_cnt);
        end
        ex_redirect = 1'b0; imem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== EN_REDIR || pc_target !== 32'h600) begin
            failures++; $display("FAIL squash_replay en=%h pc_target=%h want en=%h pc_target=600", en, pc_target, EN_REDIR);
        end
        step(); idle(); ex_target = 32'h123;
        @(negedge clk);
        checks++;
        if (en !== EN_NORMAL || pc_target !== 32'h123 || stall_cnt !== 32'd5) begin
            failures++; $display("FAIL squash_exit en=%h pc_target=%h stall=%0d want en=%h pc_target=123 stall=5", en, pc_target, stall_cnt, EN_NORMAL);
        end
        step(); idle();
    endtask

    task automatic test_dstall_priority();
        dmem_req = 1'b1; ex_redirect = 1'b1; ex_target = 32'h700;
        ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (en !== EN_NONE) begin
                failures++; $display("FAIL dstall_freeze%0d en=%h want %h", i, en, EN_NONE);
            end
            step();
        end
        checks++;
        if (flush_cnt !== 32'd2 || loaduse_cnt !== 32'd2 || stall_cnt !== 32'd7) begin
            failures++; $display("FAIL dstall_cnt flush=%0d lu=%0d stall=%0d want 2/2/7", flush_cnt, loaduse_cnt, stall_cnt);
        end
        dmem_resp = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== EN_REDIR || pc_target !== 32'h700) begin
            failures++; $display("FAIL dstall_release en=%h pc_target=%h want en=%h pc_target=700", en, pc_target, EN_REDIR);
        end
        step(); idle();
        checks++;
        if (flush_cnt !== 32'd3 || stall_cnt !== 32'd7) begin
            failures++; $display("FAIL dstall_release_cnt flush=%0d stall=%0d want 3/7", flush_cnt, stall_cnt);
        end
    endtask

    task automatic test_reset_mid_squash();
        ex_redirect = 1'b1; ex_target = 32'h840; imem_resp = 1'b0;
        step();
        ex_redirect = 1'b0; dmem_req = 1'b1;
        @(negedge clk);
        checks++;
        if (en !== EN_NONE || pc_target !== 32'h840) begin
            failures++; $display("FAIL squash_dstall en=%h pc_target=%h want en=0 pc_target=840", en, pc_target);
        end
        step(); dmem_req = 1'b0; imem_resp = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if (en !== EN_NONE || pc_target !== 32'h0 || {stall_cnt, flush_cnt, loaduse_cnt} !== 96'h0) begin
            failures++; $display("FAIL async_reset en=%h pc_target=%h cnt=%0d/%0d/%0d want all 0", en, pc_target, stall_cnt, flush_cnt, loaduse_cnt);
        end
        step(); rst = 1'b1; ex_target = 32'h123;
        @(negedge clk);
        checks++;
        if (en !== EN_NORMAL || pc_target !== 32'h123) begin
            failures++; $display("FAIL reset_abandons_squash en=%h pc_target=%h want en=%h pc_target=123", en, pc_target, EN_NORMAL);
        end
        step(); idle();
        checks++;
        if ({stall_cnt, flush_cnt, loaduse_cnt} !== 96'h0) begin
            failures++; $display("FAIL post_reset_cnt got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, loaduse_cnt);
        end
    endtask

    task automatic test_saturation();
        imem_resp = 1'b0;
        repeat (3) step();
        checks++;
        if (s_stall_cnt !== 2'b11 || stall_cnt !== 32'd3) begin
            failures++; $display("FAIL sat_reach narrow=%0d wide=%0d want 3/3", s_stall_cnt, stall_cnt);
        end
        repeat (2) step();
        checks++;
        if (s_stall_cnt !== 2'b11 || stall_cnt !== 32'd5) begin
            failures++; $display("FAIL sat_hold narrow=%0d wide=%0d want 3/5", s_stall_cnt, stall_cnt);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect_ready();
        test_redirect_wait();
        test_dstall_priority();
        test_reset_mid_squash();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
